// File: rtl/yarvi_wb.sv
`default_nettype none
// yarvi_wb: writeback/commit stage. Writes the register file, converts memory-stage
// events into a single fetch redirect (with optional trap), squashes after redirects, counts retirements.
module yarvi_wb #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] MTVEC        = 32'h80000004
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        me_valid,
  input  logic [31:0] me_pc,
  input  logic [4:0]  me_wb_rd,
  input  logic [31:0] me_wb_val,
  input  logic        me_exc_misaligned,
  input  logic        me_exc_is_store,
  input  logic [31:0] me_exc_mtval,
  input  logic        me_load_hit_store,
  input  logic        me_timer_interrupt,
  input  logic        mie_mtie,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        restart,
  output logic [31:0] restart_pc,
  output logic        trap_valid,
  output logic [31:0] trap_mepc,
  output logic [31:0] trap_mcause,
  output logic [31:0] trap_mtval,
  output logic [63:0] minstret,
  output logic        wb_flushing
);

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [3:0]  CNT_LOAD         = 4'(FLUSH_CYCLES - 1);
  localparam logic [31:0] MCAUSE_LD_MISAL  = 32'd4;
  localparam logic [31:0] MCAUSE_ST_MISAL  = 32'd6;
  localparam logic [31:0] MCAUSE_TIMER     = 32'h80000007;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic take_misaligned;
  logic take_replay;
  logic take_timer;
  logic take_commit;
  logic redirect;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Events are decoded only in RUN; everything arriving during FLUSH is dropped.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt;
    take_misaligned = 1'b0;
    take_replay     = 1'b0;
    take_timer      = 1'b0;
    take_commit     = 1'b0;
    case (state)
      RUN: begin
        if (me_exc_misaligned)
          take_misaligned = 1'b1;
        else if (me_load_hit_store)
          take_replay = 1'b1;
        else if (me_valid && me_timer_interrupt && mie_mtie)
          take_timer = 1'b1;
        else if (me_valid)
          take_commit = 1'b1;
        if (take_misaligned || take_replay || take_timer) begin
          state_nxt = FLUSH;
          cnt_nxt   = CNT_LOAD;
        end
      end
      FLUSH: begin
        if (cnt == 4'd0)
          state_nxt = RUN;
        else
          cnt_nxt = cnt - 4'd1;
      end
      default: begin
        state_nxt = RUN;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  assign redirect = take_misaligned | take_replay | take_timer;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rf_we       <= 1'b0;
      rf_waddr    <= 5'd0;
      rf_wdata    <= 32'd0;
      restart     <= 1'b0;
      restart_pc  <= 32'd0;
      trap_valid  <= 1'b0;
      trap_mepc   <= 32'd0;
      trap_mcause <= 32'd0;
      trap_mtval  <= 32'd0;
      minstret    <= 64'd0;
    end else begin
      rf_we      <= take_commit && (me_wb_rd != 5'd0);
      restart    <= redirect;
      trap_valid <= take_misaligned | take_timer;
      // x0 writes retire but leave the write-port data registers untouched.
      if (take_commit && (me_wb_rd != 5'd0)) begin
        rf_waddr <= me_wb_rd;
        rf_wdata <= me_wb_val;
      end
      if (take_commit)
        minstret <= minstret + 64'd1;
      if (take_replay)
        restart_pc <= me_pc;
      else if (take_misaligned || take_timer)
        restart_pc <= MTVEC;
      if (take_misaligned) begin
        trap_mepc   <= me_pc;
        trap_mcause <= me_exc_is_store ? MCAUSE_ST_MISAL : MCAUSE_LD_MISAL;
        trap_mtval  <= me_exc_mtval;
      end else if (take_timer) begin
        trap_mepc   <= me_pc;
        trap_mcause <= MCAUSE_TIMER;
        trap_mtval  <= 32'd0;
      end
    end
  end

  assign wb_flushing = (state == FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_yarvi_wb.sv
`default_nettype none
// tb_yarvi_wb: directed scenarios for the writeback stage with hand-computed expectations.
module tb_yarvi_wb;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        me_valid = 1'b0;
  logic [31:0] me_pc = 32'd0;
  logic [4:0]  me_wb_rd = 5'd0;
  logic [31:0] me_wb_val = 32'd0;
  logic        me_exc_misaligned = 1'b0;
  logic        me_exc_is_store = 1'b0;
  logic [31:0] me_exc_mtval = 32'd0;
  logic        me_load_hit_store = 1'b0;
  logic        me_timer_interrupt = 1'b0;
  logic        mie_mtie = 1'b0;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        restart;
  logic [31:0] restart_pc;
  logic        trap_valid;
  logic [31:0] trap_mepc;
  logic [31:0] trap_mcause;
  logic [31:0] trap_mtval;
  logic [63:0] minstret;
  logic        wb_flushing;

  int checks = 0;
  int failures = 0;

  yarvi_wb #(.FLUSH_CYCLES(2), .MTVEC(32'h80000004)) dut (
    .clock(clock), .reset(reset),
    .me_valid(me_valid), .me_pc(me_pc), .me_wb_rd(me_wb_rd), .me_wb_val(me_wb_val),
    .me_exc_misaligned(me_exc_misaligned), .me_exc_is_store(me_exc_is_store),
    .me_exc_mtval(me_exc_mtval), .me_load_hit_store(me_load_hit_store),
    .me_timer_interrupt(me_timer_interrupt), .mie_mtie(mie_mtie),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .restart(restart), .restart_pc(restart_pc),
    .trap_valid(trap_valid), .trap_mepc(trap_mepc), .trap_mcause(trap_mcause),
    .trap_mtval(trap_mtval), .minstret(minstret), .wb_flushing(wb_flushing)
  );

  always #5 clock = ~clock;

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                       input logic [31:0] val, input logic mis, input logic st,
                       input logic [31:0] mtval, input logic lhs, input logic tmr,
                       input logic mie);
    me_valid = v; me_pc = pc; me_wb_rd = rd; me_wb_val = val;
    me_exc_misaligned = mis; me_exc_is_store = st; me_exc_mtval = mtval;
    me_load_hit_store = lhs; me_timer_interrupt = tmr; mie_mtie = mie;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 32'h0, 5'd0, 32'h0, 0, 0, 32'h0, 0, 0, 0);
    repeat (n) tick();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #2;
    checks++; if ({rf_we, restart, trap_valid, wb_flushing} !== 4'b0000) begin
      failures++; $display("FAIL reset_strobes actual=%b required=0000", {rf_we, restart, trap_valid, wb_flushing}); end
    checks++; if ({rf_waddr, rf_wdata, restart_pc, trap_mepc, trap_mcause, trap_mtval} !== 165'd0) begin
      failures++; $display("FAIL reset_data actual=%h required=0", {rf_waddr, rf_wdata, restart_pc, trap_mepc, trap_mcause, trap_mtval}); end
    checks++; if (minstret !== 64'd0) begin
      failures++; $display("FAIL reset_minstret actual=%0d required=0", minstret); end
    reset = 1'b0;
  endtask

  task automatic test_commits();
    drive(1, 32'h80000000, 5'd5, 32'd1, 0, 0, 32'h0, 0, 0, 0); tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'd1}) begin
      failures++; $display("FAIL commit1 actual=we%b a%0d d%0d required=we1 a5 d1", rf_we, rf_waddr, rf_wdata); end
    drive(1, 32'h80000004, 5'd0, 32'd2, 0, 0, 32'h0, 0, 0, 0); tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'd1}) begin
      failures++; $display("FAIL commit_x0 actual=we%b a%0d d%0d required=we0 a5 d1", rf_we, rf_waddr, rf_wdata); end
    checks++; if (minstret !== 64'd2) begin
      failures++; $display("FAIL commit_x0_count actual=%0d required=2", minstret); end
    drive(1, 32'h80000008, 5'd7, 32'd3, 0, 0, 32'h0, 0, 0, 0); tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'd3}) begin
      failures++; $display("FAIL commit3 actual=we%b a%0d d%0d required=we1 a7 d3", rf_we, rf_waddr, rf_wdata); end
    idle(1);
    checks++; if ({rf_we, minstret} !== {1'b0, 64'd3}) begin
      failures++; $display("FAIL commit_idle actual=we%b n%0d required=we0 n3", rf_we, minstret); end
  endtask

  task automatic test_misaligned();
    drive(0, 32'h80000010, 5'd0, 32'h0, 1, 0, 32'h80000101, 0, 0, 0); tick();
    checks++; if ({restart, trap_valid, rf_we, wb_flushing} !== 4'b1101) begin
      failures++; $display("FAIL mis_strobes actual=%b required=1101", {restart, trap_valid, rf_we, wb_flushing}); end
    checks++; if ({restart_pc, trap_mepc, trap_mcause, trap_mtval} !== {32'h80000004, 32'h80000010, 32'd4, 32'h80000101}) begin
      failures++; $display("FAIL mis_fields actual=%h %h %h %h required=80000004 80000010 00000004 80000101",
                           restart_pc, trap_mepc, trap_mcause, trap_mtval); end
    drive(1, 32'h80000014, 5'd3, 32'hAA, 0, 0, 32'h0, 0, 0, 0); tick();
    checks++; if ({restart, trap_valid, rf_we, minstret} !== {3'b000, 64'd3}) begin
      failures++; $display("FAIL mis_squash1 actual=%b n%0d required=000 n3", {restart, trap_valid, rf_we}, minstret); end
    // a second misaligned event while squashing must be dropped
    drive(1, 32'h80000018, 5'd3, 32'hAA, 1, 1, 32'h123, 0, 0, 0); tick();
    checks++; if ({restart, trap_valid, rf_we, minstret} !== {3'b000, 64'd3}) begin
      failures++; $display("FAIL mis_squash2 actual=%b n%0d required=000 n3", {restart, trap_valid, rf_we}, minstret); end
    checks++; if ({wb_flushing, trap_mcause} !== {1'b0, 32'd4}) begin
      failures++; $display("FAIL mis_flush_end actual=fl%b c%h required=fl0 c4", wb_flushing, trap_mcause); end
    drive(1, 32'h8000001C, 5'd3, 32'hAA, 0, 0, 32'h0, 0, 0, 0); tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata, minstret} !== {1'b1, 5'd3, 32'hAA, 64'd4}) begin
      failures++; $display("FAIL mis_resume actual=we%b a%0d d%h n%0d required=we1 a3 dAA n4", rf_we, rf_waddr, rf_wdata, minstret); end
  endtask

  task automatic test_load_hit_store();
    drive(0, 32'h80000020, 5'd0, 32'h0, 0, 0, 32'h0, 1, 0, 0); tick();
    checks++; if ({restart, trap_valid, rf_we, restart_pc} !== {3'b100, 32'h80000020}) begin
      failures++; $display("FAIL lhs actual=%b pc=%h required=100 pc=80000020", {restart, trap_valid, rf_we}, restart_pc); end
    checks++; if ({minstret, trap_mcause, trap_mepc} !== {64'd4, 32'd4, 32'h80000010}) begin
      failures++; $display("FAIL lhs_hold actual=n%0d c%h e%h required=n4 c4 e80000010", minstret, trap_mcause, trap_mepc); end
    tick();
    checks++; if (restart !== 1'b0) begin
      failures++; $display("FAIL lhs_single_pulse actual=%b required=0", restart); end
    idle(1);
  endtask

  task automatic test_timer();
    drive(1, 32'h80000040, 5'd9, 32'h99, 0, 0, 32'h0, 0, 1, 1); tick();
    checks++; if ({restart, trap_valid, rf_we, minstret} !== {3'b110, 64'd4}) begin
      failures++; $display("FAIL tmr_strobes actual=%b n%0d required=110 n4", {restart, trap_valid, rf_we}, minstret); end
    checks++; if ({restart_pc, trap_mepc, trap_mcause, trap_mtval} !== {32'h80000004, 32'h80000040, 32'h80000007, 32'd0}) begin
      failures++; $display("FAIL tmr_fields actual=%h %h %h %h required=80000004 80000040 80000007 00000000",
                           restart_pc, trap_mepc, trap_mcause, trap_mtval); end
    idle(2);
    drive(1, 32'h80000040, 5'd9, 32'h99, 0, 0, 32'h0, 0, 1, 0); tick();
    checks++; if ({restart, rf_we, rf_waddr, rf_wdata, minstret} !== {2'b01, 5'd9, 32'h99, 64'd5}) begin
      failures++; $display("FAIL tmr_masked actual=r%b we%b a%0d d%h n%0d required=r0 we1 a9 d99 n5",
                           restart, rf_we, rf_waddr, rf_wdata, minstret); end
  endtask

  task automatic test_priority();
    drive(1, 32'h80000050, 5'd2, 32'h22, 1, 1, 32'h80000203, 1, 1, 1); tick();
    checks++; if ({restart, trap_valid, rf_we, restart_pc, trap_mcause, trap_mtval, minstret} !==
                  {3'b110, 32'h80000004, 32'd6, 32'h80000203, 64'd5}) begin
      failures++; $display("FAIL prio actual=%b pc=%h c=%h v=%h n%0d required=110 pc=80000004 c=6 v=80000203 n5",
                           {restart, trap_valid, rf_we}, restart_pc, trap_mcause, trap_mtval, minstret); end
    idle(2);
  endtask

  task automatic test_wrap();
    @(negedge clock);
    force dut.minstret = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.minstret;
    drive(1, 32'h80000060, 5'd0, 32'h1, 0, 0, 32'h0, 0, 0, 0); tick();
    checks++; if ({rf_we, minstret} !== {1'b0, 64'd0}) begin
      failures++; $display("FAIL wrap actual=we%b n%h required=we0 n0", rf_we, minstret); end
  endtask

  task automatic test_reset_mid_flush();
    drive(0, 32'h80000070, 5'd0, 32'h0, 0, 0, 32'h0, 1, 0, 0); tick();
    #2 reset = 1'b1;
    #1;
    checks++; if ({restart, trap_valid, rf_we, wb_flushing, restart_pc, minstret} !== {4'b0000, 32'd0, 64'd0}) begin
      failures++; $display("FAIL rst_mid_flush actual=%b pc=%h n%0d required=0000 pc=0 n0",
                           {restart, trap_valid, rf_we, wb_flushing}, restart_pc, minstret); end
    @(negedge clock);
    reset = 1'b0;
    drive(1, 32'h80000074, 5'd4, 32'h55, 0, 0, 32'h0, 0, 0, 0); tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata, minstret, wb_flushing} !== {1'b1, 5'd4, 32'h55, 64'd1, 1'b0}) begin
      failures++; $display("FAIL rst_release_commit actual=we%b a%0d d%h n%0d fl%b required=we1 a4 d55 n1 fl0",
                           rf_we, rf_waddr, rf_wdata, minstret, wb_flushing); end
  endtask

  initial begin
    test_reset();
    test_commits();
    test_misaligned();
    test_load_hit_store();
    test_timer();
    test_priority();
    test_wrap();
    test_reset_mid_flush();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
